clock_lane_rx: RTL
==================

// Module: clock_lane_rx
// PURPOSE
//  Receive-side D-PHY clock lane controller; mirror of the clock lane transmitter.
//  Watches the LP line pair, tracks the HS entry sequence LP11->LP01->LP00, and enables HS termination.
//  Reports an active HS clock and detects clock stop (EOT) and the return to LP11.
//  Sits between the LP line receivers / HS clock activity detector and the data lane receivers.
// PARAMETERS
//  SYNC_STAGES  2   flops in the lp_p/lp_n synchronizer (>=2)
//  T_LPX_MIN    2   consecutive identical synced samples needed to accept an LP code (>=1)
//  T_ZERO_MAX   64  cycles allowed in BRIDGE/TRAIL before timeout (>=2)
//  T_EOT        8   consecutive cycles with hs_act=0 that declare the clock stopped (>=1)
// PORTS
//  byte_clk     in   1  sampling clock, only clock of the block
//  byte_rst_n   in   1  asynchronous, active-low reset
//  lp_p, lp_n   in   1  asynchronous LP receiver outputs of the clock lane
//  hs_act       in   1  HS clock activity seen during the previous byte_clk period (synchronous)
//  hs_term_en   out  1  enable HS termination / HS receiver
//  clk_active   out  1  HS clock running; data lanes may be armed
//  lane_idle    out  1  lane is in the stop state (LP11 accepted)
//  err_ctrl     out  1  one-cycle pulse: illegal LP sequence
//  err_timeout  out  1  one-cycle pulse: BRIDGE or TRAIL timeout
// BEHAVIOUR
//  Reset: state=WAIT_STOP; all outputs 0; synchronizer flops=2'b11; counters=0.
//  LP filter: lp_s = {lp_p,lp_n} after SYNC_STAGES flops. stab_cnt counts consecutive equal lp_s samples, saturating.
//   The code is accepted (lp_acc) once the count reaches T_LPX_MIN.
//   A change at the pins first sampled on edge k gives state update on edge k+SYNC_STAGES+T_LPX_MIN-1.
//  States / transitions (evaluated on lp_acc; an unaccepted code leaves the state unchanged):
//   WAIT_STOP: acc 11 -> STOP; other codes ignored.
//   STOP: lane_idle=1. acc 01 -> HS_RQST; acc 10 or 00 -> err_ctrl, WAIT_STOP.
//   HS_RQST: acc 00 -> BRIDGE; acc 11 -> STOP (abort, no error); acc 10 -> err_ctrl, WAIT_STOP.
//   BRIDGE: hs_term_en=1; tmo_cnt increments every cycle.
//    hs_act=1 -> HS, with tmo_cnt cleared.
//    Else tmo_cnt==T_ZERO_MAX-1 -> err_timeout, WAIT_STOP.
//    Else acc code !=00 -> err_ctrl, WAIT_STOP.
//   HS: hs_term_en=1, clk_active=1. idle_cnt +1 when hs_act=0, cleared when hs_act=1.
//    idle_cnt==T_EOT-1 with hs_act=0 -> TRAIL.
//    acc 11 (line forced to stop mid-HS) -> err_ctrl, STOP.
//   TRAIL: hs_term_en=0, clk_active=0.
//    acc 11 -> STOP.
//    Else tmo_cnt==T_ZERO_MAX-1 -> err_timeout, WAIT_STOP.
//    hs_act=1 here is ignored.
//  Outputs are registered (Moore), valid the edge after the state update.
//   clk_active drops exactly T_EOT+1 edges after the last hs_act=1 cycle.
//  Error pulses are exactly 1 cycle wide and are registered with the state change.
//  Simultaneous events: in BRIDGE, hs_act=1 wins over the timeout and over an lp code change.
//   In HS, acc 11 wins over the EOT count.
//  tmo_cnt and idle_cnt are cleared on every state change. Widths are $clog2(param)+1; no wrap.
//  Reset asserted mid-operation forces WAIT_STOP immediately (async).
//   lane_idle stays 0 until LP11 is re-accepted after release.
// TESTING
//  1. Reset release with lp=11: lane_idle=1 on edge 2+2 (=SYNC_STAGES+T_LPX_MIN) after release; other outputs 0.
//  2. Sequence 11->01(4 cyc)->00, hs_act=1 after 5 cyc -> hs_term_en at 00 accept; clk_active next edge.
//     Then hs_act=0 for 8 cyc -> clk_active=0; lp=11 -> lane_idle=1; no error pulses.
//  3. LP 11->01->11 -> back to STOP, lane_idle=1, err_ctrl never pulses.
//  4. 11->00 directly -> one err_ctrl pulse, lane_idle=0 until 11 re-accepted.
//     A 1-cycle 01 glitch (shorter than T_LPX_MIN) -> no state change.
//  5. Reach BRIDGE, hold hs_act=0 for 64 cycles -> err_timeout 1-cycle pulse, hs_term_en=0.
//     Repeat with hs_act=1 on cycle 63 -> HS entered, no error.
//  6. In HS toggle hs_act 1,0x7,1 -> clk_active stays 1.
//     Assert byte_rst_n=0 mid-HS -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clock_lane_rx_if.sv
// LP line pair, HS activity and status signals of one D-PHY clock lane receiver.
// The master side drives the line/activity inputs; the receiver controller is the slave.
interface clock_lane_rx_if;
  logic lp_p;
  logic lp_n;
  logic hs_act;
  logic hs_term_en;
  logic clk_active;
  logic lane_idle;
  logic err_ctrl;
  logic err_timeout;

  modport master (
    output lp_p, lp_n, hs_act,
    input  hs_term_en, clk_active, lane_idle, err_ctrl, err_timeout
  );

  modport slave (
    input  lp_p, lp_n, hs_act,
    output hs_term_en, clk_active, lane_idle, err_ctrl, err_timeout
  );
endinterface

// File: rtl/clock_lane_rx.sv
// D-PHY clock lane RX controller: LP-code filter, HS entry/exit FSM and termination enable.
// Pin change to state: SYNC_STAGES+T_LPX_MIN-1 edges, outputs one edge later; no backpressure.
module clock_lane_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned T_LPX_MIN   = 2,
  parameter int unsigned T_ZERO_MAX  = 64,
  parameter int unsigned T_EOT       = 8
) (
  input  logic           i_byte_clk,
  input  logic           i_byte_rst_n,
  clock_lane_rx_if.slave io_lane
);

  localparam int unsigned WW = $clog2(SYNC_STAGES) + 1;
  localparam int unsigned SW = $clog2(T_LPX_MIN) + 1;
  localparam int unsigned TW = $clog2(T_ZERO_MAX) + 1;
  localparam int unsigned EW = $clog2(T_EOT) + 1;

  localparam logic [WW-1:0] WARM_LAST = WW'(SYNC_STAGES - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(T_LPX_MIN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(T_ZERO_MAX - 1);
  localparam logic [EW-1:0] EOT_LAST  = EW'(T_EOT - 1);

  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP11 = 2'b11;

  typedef enum logic [2:0] {
    WAIT_STOP = 3'd0,
    STOP      = 3'd1,
    HS_RQST   = 3'd2,
    BRIDGE    = 3'd3,
    HS        = 3'd4,
    TRAIL     = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync_p;
  logic [SYNC_STAGES-1:0] r_sync_n;
  logic [WW-1:0]          r_warm_cnt;
  logic [1:0]             r_lp_prev;
  logic                   r_prev_vld;
  logic [SW-1:0]          r_stab_cnt;
  state_t                 r_state;
  logic [TW-1:0]          r_tmo_cnt;
  logic [EW-1:0]          r_idle_cnt;
  logic                   r_hs_term_en;
  logic                   r_clk_active;
  logic                   r_lane_idle;
  logic                   r_err_ctrl;
  logic                   r_err_timeout;

  logic [1:0]    w_lp_s;
  logic          w_s_vld;
  logic [SW-1:0] w_stab_nxt;
  logic          w_lp_acc;
  state_t        w_state_nxt;
  logic          w_err_ctrl;
  logic          w_err_timeout;
  logic          w_state_chg;

  always_ff @(posedge i_byte_clk or negedge i_byte_rst_n) begin
    if (!i_byte_rst_n) begin
      r_sync_p <= '1;
      r_sync_n <= '1;
    end else begin
      r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], io_lane.lp_p};
      r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], io_lane.lp_n};
    end
  end

  assign w_lp_s = {r_sync_p[SYNC_STAGES-1], r_sync_n[SYNC_STAGES-1]};

  // Synchronizer reset values are not real pin samples, so they must never
  // contribute to an accepted code; counting starts once real samples emerge.
  always_ff @(posedge i_byte_clk or negedge i_byte_rst_n) begin
    if (!i_byte_rst_n) begin
      r_warm_cnt <= '0;
    end else if (r_warm_cnt != WARM_LAST) begin
      r_warm_cnt <= r_warm_cnt + 1'b1;
    end
  end

  assign w_s_vld = (r_warm_cnt == WARM_LAST);

  always_comb begin
    w_stab_nxt = '0;
    if (w_s_vld) begin
      if (r_prev_vld && (w_lp_s == r_lp_prev)) begin
        w_stab_nxt = (r_stab_cnt >= STAB_MAX) ? STAB_MAX : r_stab_cnt + 1'b1;
      end else begin
        w_stab_nxt = SW'(1);
      end
    end
  end

  assign w_lp_acc = (w_stab_nxt == STAB_MAX);

  always_ff @(posedge i_byte_clk or negedge i_byte_rst_n) begin
    if (!i_byte_rst_n) begin
      r_lp_prev  <= LP11;
      r_prev_vld <= 1'b0;
      r_stab_cnt <= '0;
    end else begin
      r_lp_prev  <= w_lp_s;
      r_prev_vld <= w_s_vld;
      r_stab_cnt <= w_stab_nxt;
    end
  end

  always_ff @(posedge i_byte_clk or negedge i_byte_rst_n) begin
    if (!i_byte_rst_n) begin
      r_state <= WAIT_STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_err_ctrl    = 1'b0;
    w_err_timeout = 1'b0;
    case (r_state)
      WAIT_STOP: begin
        if (w_lp_acc && (w_lp_s == LP11)) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_lp_acc) begin
          if (w_lp_s == LP01) begin
            w_state_nxt = HS_RQST;
          end else if (w_lp_s != LP11) begin
            w_err_ctrl  = 1'b1;
            w_state_nxt = WAIT_STOP;
          end
        end
      end
      HS_RQST: begin
        if (w_lp_acc) begin
          if (w_lp_s == LP00) begin
            w_state_nxt = BRIDGE;
          end else if (w_lp_s == LP11) begin
            w_state_nxt = STOP;
          end else if (w_lp_s == LP10) begin
            w_err_ctrl  = 1'b1;
            w_state_nxt = WAIT_STOP;
          end
        end
      end
      BRIDGE: begin
        // Clock activity takes priority over both the timeout and a line change.
        if (io_lane.hs_act) begin
          w_state_nxt = HS;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_err_timeout = 1'b1;
          w_state_nxt   = WAIT_STOP;
        end else if (w_lp_acc && (w_lp_s != LP00)) begin
          w_err_ctrl  = 1'b1;
          w_state_nxt = WAIT_STOP;
        end
      end
      HS: begin
        if (w_lp_acc && (w_lp_s == LP11)) begin
          w_err_ctrl  = 1'b1;
          w_state_nxt = STOP;
        end else if (!io_lane.hs_act && (r_idle_cnt == EOT_LAST)) begin
          w_state_nxt = TRAIL;
        end
      end
      TRAIL: begin
        if (w_lp_acc && (w_lp_s == LP11)) begin
          w_state_nxt = STOP;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_err_timeout = 1'b1;
          w_state_nxt   = WAIT_STOP;
        end
      end
      default: begin
        w_state_nxt = WAIT_STOP;
      end
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  always_ff @(posedge i_byte_clk or negedge i_byte_rst_n) begin
    if (!i_byte_rst_n) begin
      r_tmo_cnt  <= '0;
      r_idle_cnt <= '0;
    end else if (w_state_chg) begin
      r_tmo_cnt  <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (((r_state == BRIDGE) || (r_state == TRAIL)) && (r_tmo_cnt != TMO_LAST)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (r_state == HS) begin
        if (io_lane.hs_act) begin
          r_idle_cnt <= '0;
        end else if (r_idle_cnt != EOT_LAST) begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_byte_clk or negedge i_byte_rst_n) begin
    if (!i_byte_rst_n) begin
      r_hs_term_en  <= 1'b0;
      r_clk_active  <= 1'b0;
      r_lane_idle   <= 1'b0;
      r_err_ctrl    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_hs_term_en  <= (r_state == BRIDGE) || (r_state == HS);
      r_clk_active  <= (r_state == HS);
      r_lane_idle   <= (r_state == STOP);
      r_err_ctrl    <= w_err_ctrl;
      r_err_timeout <= w_err_timeout;
    end
  end

  assign io_lane.hs_term_en  = r_hs_term_en;
  assign io_lane.clk_active  = r_clk_active;
  assign io_lane.lane_idle   = r_lane_idle;
  assign io_lane.err_ctrl    = r_err_ctrl;
  assign io_lane.err_timeout = r_err_timeout;

endmodule
